// File: rtl/sysbus_mem_responder_if.sv
// sysbus_mem_responder_if: SystemBus request/response handshake bundle
interface sysbus_mem_responder_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_req_addr;
  logic        bus_req_write;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_resp_valid;
  logic        bus_resp_ready;
  logic [31:0] bus_resp_rdata;
  logic        bus_resp_error;
  modport master (
    output bus_req_valid, bus_req_addr, bus_req_write, bus_req_wdata, bus_req_wstrb, bus_resp_ready,
    input  bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_error
  );
  modport slave (
    input  bus_req_valid, bus_req_addr, bus_req_write, bus_req_wdata, bus_req_wstrb, bus_resp_ready,
    output bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_error
  );
endinterface

// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder: word RAM behind a single-outstanding SystemBus handshake with fixed latency
module sysbus_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2,
  parameter string       INIT_FILE   = ""
) (
  input logic                    clk,
  input logic                    rst,
  sysbus_mem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  logic [31:0] mem [DEPTH_WORDS];
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        write_q, error_q;
  logic [3:0]  wstrb_q;
  logic        accept, enter_resp, op_write, op_err;
  logic [31:0] op_addr, op_wdata, off;
  logic [3:0]  op_wstrb;
  logic [AW-1:0] idx;
  assign accept     = bus.bus_req_valid && bus.bus_req_ready;
  assign op_addr    = (state_q == S_IDLE) ? bus.bus_req_addr  : addr_q;
  assign op_write   = (state_q == S_IDLE) ? bus.bus_req_write : write_q;
  assign op_wdata   = (state_q == S_IDLE) ? bus.bus_req_wdata : wdata_q;
  assign op_wstrb   = (state_q == S_IDLE) ? bus.bus_req_wstrb : wstrb_q;
  assign off        = op_addr - BASE_ADDR;
  assign op_err     = (op_addr[1:0] != 2'b00) || (off >= 32'(DEPTH_WORDS) * 32'd4);
  assign idx        = off[AW+1:2];
  assign enter_resp = (state_q == S_IDLE) ? (accept && LATENCY == 1) : (state_q == S_WAIT && cnt_q == 4'd1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= bus.bus_req_addr;
        wdata_q <= bus.bus_req_wdata;
        write_q <= bus.bus_req_write;
        wstrb_q <= bus.bus_req_wstrb;
      end
      if (enter_resp) begin
        rdata_q <= (op_write || op_err) ? 32'd0 : mem[idx];
        error_q <= op_err;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (enter_resp && op_write && !op_err)
      for (int b = 0; b < 4; b++)
        if (op_wstrb[b]) mem[idx][8*b +: 8] <= op_wdata[8*b +: 8];
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE && accept) begin
      state_d = (LATENCY > 1) ? S_WAIT : S_RESP;
      cnt_d   = 4'(LATENCY - 1);
    end else if (state_q == S_WAIT) begin
      cnt_d   = cnt_q - 4'd1;
      state_d = (cnt_q == 4'd1) ? S_RESP : S_WAIT;
    end else if (state_q == S_RESP && bus.bus_resp_ready) begin
      state_d = S_IDLE;
    end
  end
  always_comb begin
    bus.bus_req_ready  = rst && (state_q == S_IDLE);
    bus.bus_resp_valid = (state_q == S_RESP);
    bus.bus_resp_rdata = rdata_q;
    bus.bus_resp_error = error_q;
  end
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb_sysbus_mem_responder: directed checks of the memory responder at latency 2 and latency 1
module tb_sysbus_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int passed = 0;
  int cyc = 0;
  sysbus_mem_responder_if bif ();
  sysbus_mem_responder_if bif1 ();
  sysbus_mem_responder #(.LATENCY(2)) u_dut (.clk(clk), .rst(rst), .bus(bif));
  sysbus_mem_responder #(.LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bif1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    bif.bus_req_valid = 1'b1;
    bif.bus_req_write = w;
    bif.bus_req_addr  = a;
    bif.bus_req_wdata = d;
    bif.bus_req_wstrb = s;
    n = 0;
    while (!bif.bus_req_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bif.bus_req_valid = 1'b0;
    lat = 0;
    while (!bif.bus_resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    rd = bif.bus_resp_rdata;
    er = bif.bus_resp_error;
    bif.bus_resp_ready = 1'b1;
    @(posedge clk); #1;
    bif.bus_resp_ready = 1'b0;
  endtask
  initial begin
    logic [31:0] rd;
    logic er;
    int lat, n, stray, prev, acc;
    logic [31:0] exp_rd [4];
    logic        req_w  [4];
    logic [31:0] req_a  [4];
    logic [31:0] req_d  [4];
    bif.bus_req_valid = 0; bif.bus_req_write = 0; bif.bus_req_addr = 0;
    bif.bus_req_wdata = 0; bif.bus_req_wstrb = 0; bif.bus_resp_ready = 0;
    bif1.bus_req_valid = 0; bif1.bus_req_write = 0; bif1.bus_req_addr = 0;
    bif1.bus_req_wdata = 0; bif1.bus_req_wstrb = 0; bif1.bus_resp_ready = 1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ready", 32'(bif.bus_req_ready), 0);
    chk("rst_rvalid", 32'(bif.bus_resp_valid), 0);
    chk("rst_rdata", bif.bus_resp_rdata, 0);
    chk("rst_error", 32'(bif.bus_resp_error), 0);
    rst = 1'b1;
    #1;
    chk("rel_ready", 32'(bif.bus_req_ready), 1);
    @(posedge clk); #1;
    // 1: full-word write then read back
    xact(1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    chk("t1_wlat", 32'(lat), 1);
    chk("t1_werr", 32'(er), 0);
    chk("t1_wrdata", rd, 0);
    xact(0, 32'h8000_0010, 0, 0, rd, er, lat);
    chk("t1_rlat", 32'(lat), 1);
    chk("t1_rerr", 32'(er), 0);
    chk("t1_rdata", rd, 32'hDEAD_BEEF);
    // 2: single-byte strobe merge
    xact(1, 32'h8000_0020, 32'h1122_3344, 4'hF, rd, er, lat);
    xact(1, 32'h8000_0020, 32'h0000_AA00, 4'b0010, rd, er, lat);
    chk("t2_strb_err", 32'(er), 0);
    xact(0, 32'h8000_0020, 0, 0, rd, er, lat);
    chk("t2_rdata", rd, 32'h1122_AA44);
    // 3: misaligned and out-of-range accesses
    xact(0, 32'h8000_0002, 0, 0, rd, er, lat);
    chk("t3_mis_err", 32'(er), 1);
    chk("t3_mis_rdata", rd, 0);
    xact(0, 32'h8000_4000, 0, 0, rd, er, lat);
    chk("t3_oor_err", 32'(er), 1);
    chk("t3_oor_rdata", rd, 0);
    xact(1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, rd, er, lat);
    xact(1, 32'h8000_4000, 32'h1234_5678, 4'hF, rd, er, lat);
    chk("t3_oorw_err", 32'(er), 1);
    xact(0, 32'h8000_0000, 0, 0, rd, er, lat);
    chk("t3_word0", rd, 32'hCAFE_F00D);
    chk("t3_word0_err", 32'(er), 0);
    // 4: response stall with a second request held behind it
    bif.bus_req_valid = 1; bif.bus_req_write = 0; bif.bus_req_addr = 32'h8000_0010;
    n = 0;
    while (!bif.bus_req_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bif.bus_req_addr = 32'h8000_0020;
    n = 0;
    while (!bif.bus_resp_valid && n < 50) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      chk("t4_stall_rvalid", 32'(bif.bus_resp_valid), 1);
      chk("t4_stall_rdata", bif.bus_resp_rdata, 32'hDEAD_BEEF);
      chk("t4_stall_err", 32'(bif.bus_resp_error), 0);
      chk("t4_stall_ready", 32'(bif.bus_req_ready), 0);
      @(posedge clk); #1;
    end
    bif.bus_resp_ready = 1;
    @(posedge clk); #1;
    bif.bus_resp_ready = 0;
    chk("t4_post_ready", 32'(bif.bus_req_ready), 1);
    chk("t4_post_rvalid", 32'(bif.bus_resp_valid), 0);
    @(posedge clk); #1;
    chk("t4_second_acc", 32'(bif.bus_req_ready), 0);
    bif.bus_req_valid = 0;
    n = 0;
    while (!bif.bus_resp_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("t4_second_rdata", bif.bus_resp_rdata, 32'h1122_AA44);
    bif.bus_resp_ready = 1;
    @(posedge clk); #1;
    bif.bus_resp_ready = 0;
    // 5: reset during WAIT drops the write
    bif.bus_req_valid = 1; bif.bus_req_write = 1; bif.bus_req_addr = 32'h8000_0010;
    bif.bus_req_wdata = 32'h5555_5555; bif.bus_req_wstrb = 4'hF;
    n = 0;
    while (!bif.bus_req_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    rst = 0;
    bif.bus_req_valid = 0;
    #1;
    chk("t5_ready", 32'(bif.bus_req_ready), 0);
    chk("t5_rvalid", 32'(bif.bus_resp_valid), 0);
    chk("t5_rdata", bif.bus_resp_rdata, 0);
    chk("t5_err", 32'(bif.bus_resp_error), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      stray += 32'(bif.bus_resp_valid);
    end
    chk("t5_stray", 32'(stray), 0);
    xact(0, 32'h8000_0010, 0, 0, rd, er, lat);
    chk("t5_prior", rd, 32'hDEAD_BEEF);
    // 6: latency 1 back-to-back with resp_ready tied high
    req_w[0] = 1; req_a[0] = 32'h8000_0000; req_d[0] = 32'hA1A1_A1A1; exp_rd[0] = 0;
    req_w[1] = 1; req_a[1] = 32'h8000_0004; req_d[1] = 32'hB2B2_B2B2; exp_rd[1] = 0;
    req_w[2] = 0; req_a[2] = 32'h8000_0000; req_d[2] = 0;             exp_rd[2] = 32'hA1A1_A1A1;
    req_w[3] = 0; req_a[3] = 32'h8000_0004; req_d[3] = 0;             exp_rd[3] = 32'hB2B2_B2B2;
    bif1.bus_req_valid = 1; bif1.bus_req_wstrb = 4'hF;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      bif1.bus_req_write = req_w[i];
      bif1.bus_req_addr  = req_a[i];
      bif1.bus_req_wdata = req_d[i];
      n = 0;
      while (!bif1.bus_req_ready && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      acc = cyc;
      chk("t6_rvalid", 32'(bif1.bus_resp_valid), 1);
      chk("t6_rdata", bif1.bus_resp_rdata, exp_rd[i]);
      chk("t6_err", 32'(bif1.bus_resp_error), 0);
      if (i > 0) chk("t6_spacing", 32'(acc - prev), 2);
      prev = acc;
    end
    bif1.bus_req_valid = 0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
